mem_wb: RTL and testbench

- Pipeline register between the MEM stage and the WB stage of the 5-stage MIPS core.
- Captures the MEM-stage result each cycle: GPR write, HI/LO write and LLbit write. Presents it to the register file, the HI/LO unit and the LLbit register in the following cycle.
- Honours the global stall vector by holding or inserting a bubble. Honours the exception flush by squashing.
- Tags each entry with a valid bit so downstream units and the optional retire counter can distinguish real instructions from bubbles.

---
 rtl/mem_wb.sv | 122 ++++++++++++
 tb/tb_mem_wb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: captures MEM-stage GPR, HI/LO and LLbit writes for WB.
// Optional retired-instruction counter enabled by defining MEMWB_RETIRE_CNT_EN.
module mem_wb #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            stall,
  input  logic                  flush,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_waddr,
  input  logic                  mem_we,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_whilo,
  input  logic [DATA_W-1:0]     mem_hi,
  input  logic [DATA_W-1:0]     mem_lo,
  input  logic                  mem_llbit_we,
  input  logic                  mem_llbit_value,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_waddr,
  output logic                  wb_we,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic                  wb_whilo,
  output logic [DATA_W-1:0]     wb_hi,
  output logic [DATA_W-1:0]     wb_lo,
  output logic                  wb_llbit_we,
  output logic                  wb_llbit_value
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      retire_cnt
`endif
);

  if (REG_ADDR_W == 0 || DATA_W == 0 || CNT_W == 0) begin : g_bad_param
    $error("mem_wb: widths must be non-zero");
  end

  logic                  w_bubble;
  logic                  w_capture;
  logic                  r_valid;
  logic [REG_ADDR_W-1:0] r_waddr;
  logic                  r_we;
  logic [DATA_W-1:0]     r_wdata;
  logic                  r_whilo;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_llbit_we;
  logic                  r_llbit_value;

  // MEM held while WB drains: insert a bubble so the held instruction commits once.
  // stall[4]=0 with stall[5]=1 is illegal and falls through to hold.
  always_comb begin
    w_bubble  = flush | (stall[4] & ~stall[5]);
    w_capture = ~stall[4] & ~stall[5];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid       <= 1'b0;
      r_waddr       <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_whilo       <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_llbit_we    <= 1'b0;
      r_llbit_value <= 1'b0;
    end else if (w_bubble) begin
      r_valid       <= 1'b0;
      r_waddr       <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_whilo       <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_llbit_we    <= 1'b0;
      r_llbit_value <= 1'b0;
    end else if (w_capture) begin
      r_valid       <= mem_valid;
      r_waddr       <= mem_waddr;
      r_we          <= mem_we & mem_valid;
      r_wdata       <= mem_wdata;
      r_whilo       <= mem_whilo & mem_valid;
      r_hi          <= mem_hi;
      r_lo          <= mem_lo;
      r_llbit_we    <= mem_llbit_we & mem_valid;
      r_llbit_value <= mem_llbit_value;
    end
  end

  assign wb_valid       = r_valid;
  assign wb_waddr       = r_waddr;
  assign wb_we          = r_we;
  assign wb_wdata       = r_wdata;
  assign wb_whilo       = r_whilo;
  assign wb_hi          = r_hi;
  assign wb_lo          = r_lo;
  assign wb_llbit_we    = r_llbit_we;
  assign wb_llbit_value = r_llbit_value;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_retire_cnt <= '0;
    end else if (!flush && w_capture && mem_valid) begin
      r_retire_cnt <= r_retire_cnt + 1'b1;
    end
  end

  assign retire_cnt = r_retire_cnt;
`endif

`ifndef SYNTHESIS
  a_legal_stall : assert property (@(posedge clk) disable iff (!rst)
    !(!flush && !stall[4] && stall[5]));
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Randomised self-checking bench for mem_wb against a rule-level reference model.
module tb_mem_wb;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    stall = '0;
  logic          flush = 1'b0;
  logic          mem_valid = 1'b0;
  logic [AW-1:0] mem_waddr = '0;
  logic          mem_we = 1'b0;
  logic [DW-1:0] mem_wdata = '0;
  logic          mem_whilo = 1'b0;
  logic [DW-1:0] mem_hi = '0;
  logic [DW-1:0] mem_lo = '0;
  logic          mem_llbit_we = 1'b0;
  logic          mem_llbit_value = 1'b0;
  logic          wb_valid;
  logic [AW-1:0] wb_waddr;
  logic          wb_we;
  logic [DW-1:0] wb_wdata;
  logic          wb_whilo;
  logic [DW-1:0] wb_hi;
  logic [DW-1:0] wb_lo;
  logic          wb_llbit_we;
  logic          wb_llbit_value;
`ifdef MEMWB_RETIRE_CNT_EN
  logic [CW-1:0] retire_cnt;
`endif

  mem_wb #(.REG_ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_llbit_we(mem_llbit_we),
    .mem_llbit_value(mem_llbit_value), .wb_valid(wb_valid), .wb_waddr(wb_waddr),
    .wb_we(wb_we), .wb_wdata(wb_wdata), .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .wb_llbit_we(wb_llbit_we), .wb_llbit_value(wb_llbit_value)
`ifdef MEMWB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what WB should hold; data fields are only meaningful when e_known.
  logic          e_valid, e_we, e_whilo, e_llwe, e_llval, e_known;
  logic [AW-1:0] e_waddr;
  logic [DW-1:0] e_wdata, e_hi, e_lo;
  int            e_cnt;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_zero();
    e_valid = 0; e_we = 0; e_whilo = 0; e_llwe = 0; e_llval = 0; e_known = 1;
    e_waddr = '0; e_wdata = '0; e_hi = '0; e_lo = '0;
  endtask

  // Applies one clock edge's worth of the pipeline-register rules to the model.
  task automatic model_edge();
    if (flush) begin
      model_zero();
    end else if (stall[4] && !stall[5]) begin
      model_zero();
    end else if (stall[4] || stall[5]) begin
      // hold
    end else begin
      e_valid = mem_valid;
      e_we    = mem_we && mem_valid;
      e_whilo = mem_whilo && mem_valid;
      e_llwe  = mem_llbit_we && mem_valid;
      e_llval = mem_llbit_value;
      e_waddr = mem_waddr;
      e_wdata = mem_wdata;
      e_hi    = mem_hi;
      e_lo    = mem_lo;
      e_known = mem_valid;
      if (mem_valid) e_cnt = (e_cnt + 1) % (1 << CW);
    end
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".valid"}, 64'(wb_valid), 64'(e_valid));
    check_eq({tag, ".we"}, 64'(wb_we), 64'(e_we));
    check_eq({tag, ".whilo"}, 64'(wb_whilo), 64'(e_whilo));
    check_eq({tag, ".llwe"}, 64'(wb_llbit_we), 64'(e_llwe));
    if (e_known) begin
      check_eq({tag, ".waddr"}, 64'(wb_waddr), 64'(e_waddr));
      check_eq({tag, ".wdata"}, 64'(wb_wdata), 64'(e_wdata));
      check_eq({tag, ".hi"}, 64'(wb_hi), 64'(e_hi));
      check_eq({tag, ".lo"}, 64'(wb_lo), 64'(e_lo));
      check_eq({tag, ".llval"}, 64'(wb_llbit_value), 64'(e_llval));
    end
`ifdef MEMWB_RETIRE_CNT_EN
    check_eq({tag, ".cnt"}, 64'(retire_cnt), 64'(e_cnt));
`endif
  endtask

  // Inputs are driven at the falling edge; the model and checks run around the rising edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] a, input logic we,
                       input logic [DW-1:0] d, input logic hl, input logic [DW-1:0] hi,
                       input logic [DW-1:0] lo, input logic llwe, input logic llv,
                       input logic [5:0] st, input logic fl);
    mem_valid = v; mem_waddr = a; mem_we = we; mem_wdata = d; mem_whilo = hl;
    mem_hi = hi; mem_lo = lo; mem_llbit_we = llwe; mem_llbit_value = llv;
    stall = st; flush = fl;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    model_zero();
    e_cnt = 0;
    #1 check_all("reset_async");
    @(negedge clk);
  endtask

  initial begin
    model_zero();
    e_cnt = 0;
    #3 check_all("reset_init");
    @(negedge clk);
    rst = 1'b1;
    drive(1, 5'd9, 1, 32'h12345678, 1, 32'h1, 32'h2, 1, 1, 6'b0, 0);
    step("pre_reset");
    // Async reset mid-cycle with non-zero outputs; checked before the next edge.
    do_reset();
    drive(1, 5'd3, 1, 32'hDEADBEEF, 0, '0, '0, 0, 0, 6'b0, 0);
    rst = 1'b1;
    step("first_capture");
    check_eq("first_capture.lit", {32'(wb_waddr), wb_wdata}, {32'd3, 32'hDEADBEEF});

    // Hold
    drive(1, 5'd7, 1, 32'h11, 0, '0, '0, 0, 0, 6'b0, 0);
    step("hold_load");
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(i + 20), 1, $urandom, 1, $urandom, $urandom, 1, 1, 6'b110000, 0);
      step("hold");
      check_eq("hold.lit", {32'(wb_waddr), wb_wdata}, {32'd7, 32'h11});
    end

    // Bubble then release: held instruction commits once
    drive(1, 5'd12, 1, 32'hCAFE, 1, 32'h3, 32'h4, 1, 0, 6'b010000, 0);
    step("bubble");
    check_eq("bubble.lit", 64'({wb_we, wb_whilo, wb_llbit_we, wb_valid}), 64'(0));
    stall = 6'b0;
    step("release");
    check_eq("release.lit", 64'({wb_we, wb_valid, wb_waddr}), 64'({2'b11, 5'd12}));
    mem_valid = 0;
    step("after_release");

    // Flush beats stall
    drive(1, 5'd1, 1, 32'h9, 1, 32'h5, 32'h6, 1, 1, 6'b110000, 1);
    step("flush");
    check_eq("flush.lit", {31'(wb_whilo), wb_valid, wb_hi}, 64'(0));
    check_eq("flush.lo", 64'(wb_lo), 64'(0));

    // LLbit and HI/LO path, valid then invalid
    drive(1, 5'd2, 0, 32'h0, 1, 32'hAAAA0000, 32'h0000BBBB, 1, 1, 6'b0, 0);
    step("llhilo");
    check_eq("llhilo.lit", {wb_hi, wb_lo}, {32'hAAAA0000, 32'h0000BBBB});
    mem_valid = 0;
    step("llhilo_inv");

    // Retire counter: 17 valid captures, one flush and one bubble interleaved
    do_reset();
    rst = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(1, 5'(i), 1, 32'(i), 0, '0, '0, 0, 0, (i == 8) ? 6'b010000 : 6'b0, i == 4);
      step("retire");
    end
`ifdef MEMWB_RETIRE_CNT_EN
    check_eq("retire.lit", 64'(retire_cnt), 64'(1));
`endif

    // Random legal stimulus
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [5:0] st;
      r = $urandom_range(0, 9);
      st = 6'($urandom) & 6'b001111;
      if (r >= 8) st[5:4] = 2'b11;
      else if (r >= 6) st[5:4] = 2'b01;
      drive(1'($urandom), 5'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
            $urandom, 1'($urandom), 1'($urandom), st, $urandom_range(0, 9) == 0);
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
